// File: rtl/title_display_ctrl.sv
// rtl/title_display_ctrl.sv - title drop/blink/hold sequencer feeding a 128x16 title bitmap
// Animates the title top edge, does the registered hit test and gates the bitmap request.
module title_display_ctrl #(
  parameter int TITLE_W      = 128,
  parameter int TITLE_H      = 16,
  parameter int TARGET_X     = 256,
  parameter int START_Y      = 0,
  parameter int TARGET_Y     = 100,
  parameter int DROP_STEP    = 2,
  parameter int BLINK_PERIOD = 30,
  parameter int HOLD_FRAMES  = 180
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startTitle,
  input  logic        abort,
  input  logic        bitmapDrawingRequest,
  output logic        InsideRectangle,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        titleDrawingRequest,
  output logic [10:0] topLeftY,
  output logic        busy,
  output logic        done
);

  localparam logic [11:0] X_LO       = 12'(TARGET_X);
  localparam logic [11:0] X_HI       = 12'(TARGET_X + TITLE_W - 1);
  localparam logic [11:0] H_M1       = 12'(TITLE_H - 1);
  localparam logic [10:0] START_Y_W  = 11'(START_Y);
  localparam logic [10:0] TARGET_Y_W = 11'(TARGET_Y);
  localparam logic [11:0] TARGET_Y12 = 12'(TARGET_Y);
  localparam logic [11:0] STEP_12    = 12'(DROP_STEP);
  localparam logic [7:0]  BLINK_LAST = 8'(BLINK_PERIOD - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DROP, S_HOLD, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [10:0] r_top_y, w_top_y_nxt;
  logic [7:0]  r_frame_cnt, w_frame_nxt;
  logic [7:0]  r_blink_cnt, w_blink_nxt;
  logic        r_visible, w_visible_nxt;
  logic        w_done_nxt;
  logic        r_inside, r_busy, r_done;
  logic [10:0] r_off_x, r_off_y;

  // 12-bit sum so a large step near the bottom of the range cannot wrap past TARGET_Y
  logic [11:0] w_y_step;
  assign w_y_step = {1'b0, r_top_y} + STEP_12;

  always_comb begin
    w_state_nxt   = r_state;
    w_top_y_nxt   = r_top_y;
    w_frame_nxt   = r_frame_cnt;
    w_blink_nxt   = r_blink_cnt;
    w_visible_nxt = r_visible;
    w_done_nxt    = 1'b0;
    if (abort) begin
      w_state_nxt   = S_IDLE;
      w_top_y_nxt   = START_Y_W;
      w_visible_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (startTitle) begin
            w_state_nxt   = S_DROP;
            w_top_y_nxt   = START_Y_W;
            w_visible_nxt = 1'b1;
          end
        end
        S_DROP: begin
          if (startOfFrame) begin
            if (w_y_step >= TARGET_Y12) begin
              w_top_y_nxt = TARGET_Y_W;
              w_state_nxt = S_HOLD;
              w_frame_nxt = 8'd0;
              w_blink_nxt = 8'd0;
            end else begin
              w_top_y_nxt = w_y_step[10:0];
            end
          end
        end
        S_HOLD: begin
          if (startOfFrame) begin
            w_frame_nxt = r_frame_cnt + 8'd1;
            w_blink_nxt = r_blink_cnt + 8'd1;
            if (r_blink_cnt == BLINK_LAST) begin
              w_visible_nxt = ~r_visible;
              w_blink_nxt   = 8'd0;
            end
            if (r_frame_cnt == HOLD_LAST) begin
              w_state_nxt   = S_DONE;
              w_visible_nxt = 1'b1;
              w_done_nxt    = 1'b1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  logic [11:0] w_px12, w_py12, w_top12;
  logic        w_hit;
  assign w_px12  = {1'b0, pixelX};
  assign w_py12  = {1'b0, pixelY};
  assign w_top12 = {1'b0, r_top_y};
  assign w_hit   = (r_state != S_IDLE) &&
                   (w_px12 >= X_LO) && (w_px12 <= X_HI) &&
                   (w_py12 >= w_top12) && (w_py12 <= w_top12 + H_M1);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_top_y     <= START_Y_W;
      r_frame_cnt <= 8'd0;
      r_blink_cnt <= 8'd0;
      r_visible   <= 1'b0;
      r_inside    <= 1'b0;
      r_off_x     <= 11'd0;
      r_off_y     <= 11'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_top_y     <= w_top_y_nxt;
      r_frame_cnt <= w_frame_nxt;
      r_blink_cnt <= w_blink_nxt;
      r_visible   <= w_visible_nxt;
      r_inside    <= w_hit;
      r_off_x     <= w_hit ? (pixelX - X_LO[10:0]) : 11'd0;
      r_off_y     <= w_hit ? (pixelY - r_top_y) : 11'd0;
      r_busy      <= (w_state_nxt == S_DROP) || (w_state_nxt == S_HOLD);
      r_done      <= w_done_nxt;
    end
  end

  assign InsideRectangle     = r_inside;
  assign offsetX             = r_off_x;
  assign offsetY             = r_off_y;
  assign topLeftY            = r_top_y;
  assign busy                = r_busy;
  assign done                = r_done;
  assign titleDrawingRequest = bitmapDrawingRequest && r_visible && (r_state != S_IDLE);

endmodule

// File: tb/tb_title_display_ctrl.sv
// tb/tb_title_display_ctrl.sv - scoreboard bench for title_display_ctrl
module tb_title_display_ctrl;

  logic        clk = 1'b0;
  logic        resetN, startOfFrame, startTitle, abort, bitmapDrawingRequest;
  logic [10:0] pixelX, pixelY;
  logic        InsideRectangle, titleDrawingRequest, busy, done;
  logic [10:0] offsetX, offsetY, topLeftY;

  title_display_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .startTitle(startTitle), .abort(abort),
    .bitmapDrawingRequest(bitmapDrawingRequest),
    .InsideRectangle(InsideRectangle), .offsetX(offsetX), .offsetY(offsetY),
    .titleDrawingRequest(titleDrawingRequest), .topLeftY(topLeftY),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       name;
    logic        ins;
    logic [10:0] ox;
    logic [10:0] oy;
    logic [10:0] ty;
    logic        b;
    logic        d;
    logic        t;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      n_checks++;
      if (e.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: stale expectation for cycle %0d, now %0d", e.name, e.cyc, cyc);
      end else if (InsideRectangle !== e.ins || offsetX !== e.ox || offsetY !== e.oy ||
                   topLeftY !== e.ty || busy !== e.b || done !== e.d ||
                   titleDrawingRequest !== e.t) begin
        n_errors++;
        $display("FAIL %s: got ins=%0d ox=%0d oy=%0d top=%0d busy=%0d done=%0d tdr=%0d, expected ins=%0d ox=%0d oy=%0d top=%0d busy=%0d done=%0d tdr=%0d",
                 e.name, InsideRectangle, offsetX, offsetY, topLeftY, busy, done,
                 titleDrawingRequest, e.ins, e.ox, e.oy, e.ty, e.b, e.d, e.t);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic ins, input logic [10:0] ox,
                     input logic [10:0] oy, input logic [10:0] ty,
                     input logic b, input logic d, input logic t);
    exp_t x;
    x.cyc = cyc; x.name = name; x.ins = ins; x.ox = ox; x.oy = oy;
    x.ty = ty; x.b = b; x.d = d; x.t = t;
    q.push_back(x);
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
      tick();
    end
  endtask

  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
    tick();
  endtask

  task automatic finish_hold();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("done_pulse", 0, 0, 0, 100, 0, 1, 1);
    tick();
    chk("done_steady", 0, 0, 0, 100, 0, 0, 1);
  endtask

  task automatic full_seq();
    startTitle = 1'b1;
    tick();
    startTitle = 1'b0;
    chk("seq_start", 0, 0, 0, 0, 1, 0, 1);
    run_frames(50);
    chk("seq_hold_entry", 0, 0, 0, 100, 1, 0, 1);
    run_frames(179);
    chk("seq_hold179", 0, 0, 0, 100, 1, 0, 0);
    finish_hold();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; startTitle = 1'b0; abort = 1'b0;
    pixelX = 11'd0; pixelY = 11'd0; bitmapDrawingRequest = 1'b1;
    tick();
    chk("reset", 0, 0, 0, 0, 0, 0, 0);
    tick();
    resetN = 1'b1;

    startTitle = 1'b1;
    tick();
    startTitle = 1'b0;
    chk("start", 0, 0, 0, 0, 1, 0, 1);
    run_frames(49);
    chk("drop49", 0, 0, 0, 98, 1, 0, 1);
    run_frames(1);
    chk("hold_entry", 0, 0, 0, 100, 1, 0, 1);

    pix(256, 100); chk("hit_top_left", 1, 0, 0, 100, 1, 0, 1);
    pix(383, 115); chk("hit_bot_right", 1, 127, 15, 100, 1, 0, 1);
    pix(384, 100); chk("miss_right", 0, 0, 0, 100, 1, 0, 1);
    pix(256, 116); chk("miss_below", 0, 0, 0, 100, 1, 0, 1);
    pix(255, 100); chk("miss_left", 0, 0, 0, 100, 1, 0, 1);
    pix(256, 99);  chk("miss_above", 0, 0, 0, 100, 1, 0, 1);
    pix(0, 0);

    startTitle = 1'b1;
    tick();
    startTitle = 1'b0;
    chk("start_in_hold", 0, 0, 0, 100, 1, 0, 1);

    run_frames(29); chk("hold29_vis", 0, 0, 0, 100, 1, 0, 1);
    run_frames(1);  chk("hold30_blank", 0, 0, 0, 100, 1, 0, 0);
    run_frames(29); chk("hold59_blank", 0, 0, 0, 100, 1, 0, 0);
    run_frames(1);  chk("hold60_vis", 0, 0, 0, 100, 1, 0, 1);
    run_frames(119); chk("hold179", 0, 0, 0, 100, 1, 0, 0);
    finish_hold();

    startTitle = 1'b1;
    startOfFrame = 1'b1;
    tick();
    startTitle = 1'b0;
    startOfFrame = 1'b0;
    chk("restart_with_sof", 0, 0, 0, 0, 1, 0, 1);
    run_frames(20);
    chk("drop40", 0, 0, 0, 40, 1, 0, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_drop", 0, 0, 0, 0, 0, 0, 0);

    full_seq();
    abort = 1'b1;
    startTitle = 1'b1;
    tick();
    abort = 1'b0;
    startTitle = 1'b0;
    chk("abort_and_start", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("idle_after_abort", 0, 0, 0, 0, 0, 0, 0);

    startTitle = 1'b1;
    tick();
    startTitle = 1'b0;
    run_frames(60);
    pix(300, 105); chk("hit_mid_hold", 1, 44, 5, 100, 1, 0, 1);
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    chk("reset_mid_hold", 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("idle_after_reset", 0, 0, 0, 0, 0, 0, 0);
    pix(0, 0);
    full_seq();

    tick();
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    n_checks++;
    if (done_seen != 3) begin
      n_errors++;
      $display("FAIL done_count: got %0d pulses, expected 3", done_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
